// File: rtl/xyolo_packer_if.sv
// Purpose: handshake/data bundle between the YOLO result stream, the packer and the DMA write side.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry the stall; master drives the packer, slave is the packer.
// Signals: sat_en, in_valid, in_data, flush, out_ready (towards packer);
//          in_ready, out_valid, out_data, word_cnt, idle (from packer).
interface xyolo_packer_if #(
   parameter int DATA_W = 32,
   parameter int OUT_W  = 16,
   parameter int BUS_W  = 256
);
   logic              sat_en;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [BUS_W-1:0]  out_data;
   logic [15:0]       word_cnt;
   logic              idle;

   // Producer/consumer side: feeds samples, takes packed words.
   modport master (
      output sat_en, in_valid, in_data, flush, out_ready,
      input  in_ready, out_valid, out_data, word_cnt, idle
   );

   // Packer side.
   modport slave (
      input  sat_en, in_valid, in_data, flush, out_ready,
      output in_ready, out_valid, out_data, word_cnt, idle
   );
endinterface

// File: rtl/xyolo_packer.sv
// Purpose: narrow DATA_W samples to OUT_W lanes (saturate or truncate), pack BUS_W/OUT_W lanes per word, queue words in a FIFO.
// Latency: a word completed on edge k shows out_valid=1 right after edge k when the FIFO was empty.
// Backpressure: in_ready = !fifo_full & !flush_pend from registered state only; out_ready only pops the FIFO.
// Ports: clk, rst (async active-high); bus (slave modport): sat_en, in_valid/in_ready/in_data,
//        flush, out_valid/out_ready/out_data, word_cnt (pops since reset, wraps), idle.
module xyolo_packer #(
   parameter int DATA_W     = 32,
   parameter int OUT_W      = 16,
   parameter int BUS_W      = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   xyolo_packer_if.slave bus
);
   localparam int N_LANES = BUS_W / OUT_W;
   localparam int LANE_W  = (N_LANES > 1) ? $clog2(N_LANES) : 1;
   localparam int PTR_W   = $clog2(FIFO_DEPTH);

   // Signed OUT_W limits, sign-extended to DATA_W for the clamp compare.
   localparam logic signed [DATA_W-1:0] C_MAX = DATA_W'((64'd1 << (OUT_W - 1)) - 64'd1);
   localparam logic signed [DATA_W-1:0] C_MIN = ~C_MAX;

   logic [LANE_W-1:0] r_lane_cnt;
   logic [BUS_W-1:0]  r_pack;
   logic              r_flush_pend;
   logic [BUS_W-1:0]  r_mem [FIFO_DEPTH];
   // One extra pointer bit separates full from empty.
   logic [PTR_W:0]    r_wr_ptr;
   logic [PTR_W:0]    r_rd_ptr;
   logic [15:0]       r_word_cnt;

   logic              w_full;
   logic              w_empty;
   logic              w_in_ready;
   logic              w_accept;
   logic              w_pop;
   logic              w_lane_last;
   logic              w_word_push;
   logic              w_flush_push;
   logic              w_push;
   logic [OUT_W-1:0]  w_lane_dat;
   logic [BUS_W-1:0]  w_pack_upd;
   logic [BUS_W-1:0]  w_push_dat;

   assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                    (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);

   assign w_in_ready  = !w_full && !r_flush_pend;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_pop       = !w_empty && bus.out_ready;
   assign w_lane_last = (r_lane_cnt == LANE_W'(N_LANES - 1));

   // Accept and flush-push are mutually exclusive: accept needs !flush_pend,
   // flush-push needs flush_pend. Both need !full, so no push ever hits a full FIFO.
   assign w_word_push  = w_accept && w_lane_last;
   assign w_flush_push = r_flush_pend && !w_full && (r_lane_cnt != '0);
   assign w_push       = w_word_push || w_flush_push;

   // Narrowing: clamp to the signed OUT_W range, or keep the low bits.
   always_comb begin
      w_lane_dat = bus.in_data[OUT_W-1:0];
      if (bus.sat_en) begin
         if ($signed(bus.in_data) > C_MAX) begin
            w_lane_dat = C_MAX[OUT_W-1:0];
         end else if ($signed(bus.in_data) < C_MIN) begin
            w_lane_dat = C_MIN[OUT_W-1:0];
         end
      end
   end

   // Pack register with the incoming lane inserted at lane_cnt.
   always_comb begin
      w_pack_upd = r_pack;
      w_pack_upd[r_lane_cnt*OUT_W +: OUT_W] = w_lane_dat;
   end

   // A completing sample goes straight into the FIFO together with the
   // earlier lanes; a flush pushes the pack register as-is (unwritten lanes are 0).
   assign w_push_dat = w_word_push ? w_pack_upd : r_pack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lane_cnt <= '0;
         r_pack     <= '0;
      end else if (w_push) begin
         r_lane_cnt <= '0;
         r_pack     <= '0;
      end else if (w_accept) begin
         r_lane_cnt <= r_lane_cnt + 1'b1;
         r_pack     <= w_pack_upd;
      end
   end

   // While pending, the flush resolves on the first non-full cycle; a new flush
   // pulse during that time merges into the pending one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flush_pend <= 1'b0;
      end else if (r_flush_pend) begin
         r_flush_pend <= w_full;
      end else begin
         r_flush_pend <= bus.flush;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_word_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= w_push_dat;
            r_wr_ptr                   <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_word_cnt <= r_word_cnt + 16'd1;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = !w_empty;
   assign bus.out_data  = r_mem[r_rd_ptr[PTR_W-1:0]];
   assign bus.word_cnt  = r_word_cnt;
   assign bus.idle      = w_empty && (r_lane_cnt == '0) && !r_flush_pend;
endmodule

// File: tb/tb_xyolo_packer.sv
// Purpose: self-checking bench for xyolo_packer: queue-based reference model plus directed literal checks.
// Latency: model predicts outputs for every cycle, compared on the falling edge.
// Backpressure: stimulus holds in_valid/in_data until in_ready was seen high at an edge.
module tb_xyolo_packer;
   localparam int DATA_W     = 32;
   localparam int OUT_W      = 16;
   localparam int BUS_W      = 256;
   localparam int FIFO_DEPTH = 4;
   localparam int N_LANES    = BUS_W / OUT_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   xyolo_packer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .BUS_W(BUS_W)) bus ();

   xyolo_packer #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .BUS_W(BUS_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: queued words, lanes of the word being built, pending flush, pops.
   logic [BUS_W-1:0] m_q[$];
   logic [OUT_W-1:0] m_lanes[$];
   bit               m_fp;
   logic [15:0]      m_cnt;
   logic [BUS_W-1:0] got[$];

   task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timeout at %0t", name, $time);
   endtask

   function automatic logic [OUT_W-1:0] narrow(input logic [DATA_W-1:0] d, input logic s);
      longint v;
      v = longint'($signed(d));
      if (s && v > 32767)  return 16'h7fff;
      if (s && v < -32768) return 16'h8000;
      return d[OUT_W-1:0];
   endfunction

   function automatic logic [BUS_W-1:0] pack_lanes(input logic [OUT_W-1:0] l[$]);
      logic [BUS_W-1:0] w;
      w = '0;
      for (int i = 0; i < l.size(); i++) w[i*OUT_W +: OUT_W] = l[i];
      return w;
   endfunction

   // Compares DUT state (after the last rising edge) with the model, then
   // advances the model with the inputs that the next rising edge will see.
   task automatic monitor();
      bit full_b, old_fp, do_pop, acc;
      forever begin
         @(negedge clk);
         if (rst) begin
            m_q.delete();
            m_lanes.delete();
            m_fp  = 1'b0;
            m_cnt = '0;
         end
         chk("m_in_ready",  BUS_W'(bus.in_ready),  BUS_W'((m_q.size() < FIFO_DEPTH) && !m_fp));
         chk("m_out_valid", BUS_W'(bus.out_valid), BUS_W'(m_q.size() != 0));
         if (m_q.size() != 0) chk("m_out_data", bus.out_data, m_q[0]);
         chk("m_word_cnt",  BUS_W'(bus.word_cnt),  BUS_W'(m_cnt));
         chk("m_idle",      BUS_W'(bus.idle),
             BUS_W'(m_q.size() == 0 && m_lanes.size() == 0 && !m_fp));
         if (!rst) begin
            full_b = (m_q.size() == FIFO_DEPTH);
            old_fp = m_fp;
            do_pop = (m_q.size() != 0) && bus.out_ready;
            acc    = bus.in_valid && !full_b && !old_fp;
            if (do_pop) begin
               got.push_back(bus.out_data);
               void'(m_q.pop_front());
               m_cnt = m_cnt + 16'd1;
            end
            if (acc) begin
               m_lanes.push_back(narrow(bus.in_data, bus.sat_en));
               if (m_lanes.size() == N_LANES) begin
                  m_q.push_back(pack_lanes(m_lanes));
                  m_lanes.delete();
               end
            end
            if (old_fp) begin
               if (!full_b) begin
                  if (m_lanes.size() != 0) begin
                     m_q.push_back(pack_lanes(m_lanes));
                     m_lanes.delete();
                  end
                  m_fp = 1'b0;
               end
            end else if (bus.flush) begin
               m_fp = 1'b1;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic s);
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.sat_en   = s;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 400);
      if (!acc) timeout_fail("send");
      bus.in_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.idle && n < 200);
      tick();
      if (!bus.idle) timeout_fail("wait_idle");
   endtask

   initial begin
      int b;
      logic [BUS_W-1:0] exp;
      logic [BUS_W-1:0] w;
      logic [15:0] wc;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.sat_en    = 1'b1;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready",  BUS_W'(bus.in_ready),  BUS_W'(1));
      chk("rst_out_valid", BUS_W'(bus.out_valid), BUS_W'(0));
      chk("rst_out_data",  bus.out_data,          '0);
      chk("rst_idle",      BUS_W'(bus.idle),      BUS_W'(1));
      chk("rst_word_cnt",  BUS_W'(bus.word_cnt),  BUS_W'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // T1: lanes 0..15 = 0..15
      bus.out_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(DATA_W'(i), 1'b1);
      exp = 256'h000f_000e_000d_000c_000b_000a_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000;
      chk("t1_out_valid", BUS_W'(bus.out_valid), BUS_W'(1));
      chk("t1_out_data",  bus.out_data, exp);
      tick();
      chk("t1_word_cnt",  BUS_W'(bus.word_cnt), BUS_W'(1));
      chk("t1_idle",      BUS_W'(bus.idle),     BUS_W'(1));
      chk("t1_got",       got[0], exp);

      // T2: narrowing
      send(32'h0001_2345, 1'b1);
      send(32'hFFFF_0000, 1'b1);
      send(32'hFFFF_FFFE, 1'b1);
      send(32'h0001_2345, 1'b0);
      do_flush();
      wait_idle();
      exp = '0;
      exp[63:0] = 64'h2345_fffe_8000_7fff;
      chk("t2_word", got[got.size()-1], exp);

      // T3: FIFO fills, then drains in order
      bus.out_ready = 1'b0;
      b = got.size();
      for (int k = 0; k < 64; k++) send(DATA_W'(k), 1'b1);
      chk("t3_in_ready_full", BUS_W'(bus.in_ready),  BUS_W'(0));
      chk("t3_out_valid",     BUS_W'(bus.out_valid), BUS_W'(1));
      wc = bus.word_cnt;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'd64;
      repeat (4) tick();
      chk("t3_stalled", BUS_W'(bus.in_ready), BUS_W'(0));
      chk("t3_no_pop",  BUS_W'(bus.word_cnt), BUS_W'(wc));
      bus.out_ready = 1'b1;
      for (int k = 64; k < 80; k++) send(DATA_W'(k), 1'b1);
      wait_idle();
      chk("t3_count", BUS_W'(got.size()), BUS_W'(b + 5));
      for (int j = 0; j < 5; j++) begin
         w = got[b+j];
         chk("t3_lane0",  BUS_W'(w[15:0]),    BUS_W'(j*16));
         chk("t3_lane15", BUS_W'(w[255:240]), BUS_W'(j*16 + 15));
      end

      // T4: partial flush, empty flush, flush with completing sample
      send(32'd7, 1'b1);
      send(32'd8, 1'b1);
      send(32'd9, 1'b1);
      do_flush();
      wait_idle();
      exp = '0;
      exp[47:0] = 48'h0009_0008_0007;
      chk("t4_partial", got[got.size()-1], exp);
      b = got.size();
      do_flush();
      repeat (4) tick();
      chk("t4_empty_flush", BUS_W'(got.size()), BUS_W'(b));
      chk("t4_idle",        BUS_W'(bus.idle),   BUS_W'(1));
      for (int i = 0; i < 15; i++) send(DATA_W'(32 + i), 1'b1);
      bus.flush = 1'b1;
      send(32'd47, 1'b1);
      bus.flush = 1'b0;
      wait_idle();
      repeat (3) tick();
      chk("t4_one_word", BUS_W'(got.size()), BUS_W'(b + 1));
      w = got[got.size()-1];
      chk("t4_lane15",   BUS_W'(w[255:240]), BUS_W'(47));

      // T5: flush fills FIFO, held flush while full, release by one pop
      bus.out_ready = 1'b0;
      b = got.size();
      for (int k = 0; k < 53; k++) send(DATA_W'(200 + k), 1'b1);
      do_flush();
      tick();
      chk("t5_in_ready_full", BUS_W'(bus.in_ready), BUS_W'(0));
      chk("t5_not_idle",      BUS_W'(bus.idle),     BUS_W'(0));
      do_flush();
      repeat (3) tick();
      chk("t5_pend_held", BUS_W'(bus.idle),     BUS_W'(0));
      chk("t5_pend_rdy",  BUS_W'(bus.in_ready), BUS_W'(0));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("t5_after_pop", BUS_W'(bus.in_ready), BUS_W'(0));
      tick();
      chk("t5_released",  BUS_W'(bus.in_ready), BUS_W'(1));
      bus.out_ready = 1'b1;
      wait_idle();
      chk("t5_count", BUS_W'(got.size()), BUS_W'(b + 4));
      w = got[b+3];
      chk("t5_partial", BUS_W'(w[95:0]), BUS_W'(96'h0000_00fc_00fb_00fa_00f9_00f8));

      // T6: reset mid-operation
      bus.out_ready = 1'b0;
      for (int k = 0; k < 42; k++) send(DATA_W'(k), 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk("t6_out_valid", BUS_W'(bus.out_valid), BUS_W'(0));
      chk("t6_word_cnt",  BUS_W'(bus.word_cnt),  BUS_W'(0));
      chk("t6_idle",      BUS_W'(bus.idle),      BUS_W'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      bus.out_ready = 1'b1;
      b = got.size();
      for (int k = 0; k < 16; k++) send(DATA_W'(100 + k), 1'b1);
      wait_idle();
      chk("t6_count", BUS_W'(got.size()), BUS_W'(b + 1));
      w = got[b];
      chk("t6_lane0",    BUS_W'(w[15:0]),    BUS_W'(100));
      chk("t6_lane15",   BUS_W'(w[255:240]), BUS_W'(115));
      chk("t6_word_cnt_after", BUS_W'(bus.word_cnt), BUS_W'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
